// File: rtl/phys_pkg.sv
// Shared types and constants for the doodle physics datapath.
// Used by the sequencer and by the doodle and block managers.
package phys_pkg;

  localparam int          COORD_W             = 32;
  localparam int unsigned DEFAULT_TICK_DIV    = 833333;
  localparam int unsigned DEFAULT_SCROLL_LINE = 300;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_COLLIDE,
    S_MOVE,
    S_DECIDE,
    S_SCROLL,
    S_OVER
  } phys_state_t;

  // A state counts as busy while a frame sequence is in flight.
  function automatic logic isBusy(input phys_state_t s);
    return (s == S_COLLIDE) || (s == S_MOVE) || (s == S_DECIDE) || (s == S_SCROLL);
  endfunction

endpackage

// File: rtl/physics_sequencer_if.sv
// Bundles the physics sequencer's control, handshake and status signals.
// The timeout_err status line only exists when PHYS_WATCHDOG_EN is defined.
interface physics_sequencer_if;
  import phys_pkg::*;

  logic               enable;
  logic [COORD_W-1:0] doodle_y;
  logic               falling;
  logic               collide_req;
  logic               collide_done;
  logic               collide_hit;
  logic               hit;
  logic               move_req;
  logic               move_done;
  logic               scroll_req;
  logic [COORD_W-1:0] scroll_amount;
  logic               scroll_done;
  logic               busy;
  logic               game_over;
  logic               overrun;
  logic [15:0]        frame_count;
`ifdef PHYS_WATCHDOG_EN
  logic               timeout_err;
`endif

  // Sequencer side drives requests and status, the rest of the game answers.
  modport master (
    input  enable, doodle_y, falling, collide_done, collide_hit, move_done, scroll_done,
    output collide_req, hit, move_req, scroll_req, scroll_amount, busy, game_over,
           overrun, frame_count
`ifdef PHYS_WATCHDOG_EN
    , output timeout_err
`endif
  );

  modport slave (
    output enable, doodle_y, falling, collide_done, collide_hit, move_done, scroll_done,
    input  collide_req, hit, move_req, scroll_req, scroll_amount, busy, game_over,
           overrun, frame_count
`ifdef PHYS_WATCHDOG_EN
    , input timeout_err
`endif
  );

endinterface

// File: rtl/tick_divider.sv
// Divides the system clock into a one-cycle tick every TICK_DIV cycles.
// The count is held at zero whenever i_enable is low.
module tick_divider #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_tick;

  // The tick is registered so it lines up with the counter wrapping to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (!i_enable) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (r_count == LAST) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + CNT_W'(1);
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/physics_sequencer.sv
// Per-frame physics controller: on every tick runs collide -> move -> optional scroll.
// Define PHYS_WATCHDOG_EN to abort a handshake that stalls for TIMEOUT cycles.
module physics_sequencer
  import phys_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEFAULT_TICK_DIV,
  parameter int unsigned SCROLL_LINE = DEFAULT_SCROLL_LINE
`ifdef PHYS_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT     = 255
`endif
) (
  input logic                 clk,
  input logic                 reset,
  physics_sequencer_if.master bus
);

  localparam logic [COORD_W-1:0] SCROLL_Y = COORD_W'(SCROLL_LINE);

  phys_state_t        r_state;
  logic               r_collideReq;
  logic               r_moveReq;
  logic               r_scrollReq;
  logic               r_hit;
  logic               r_gameOver;
  logic               r_overrun;
  logic [COORD_W-1:0] r_scrollAmount;
  logic [15:0]        r_frameCount;
  logic               w_tick;
  logic               w_timeout;

  // The divider freezes once the game is lost.
  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .i_enable (bus.enable && (r_state != S_OVER)),
    .o_tick   (w_tick)
  );

`ifdef PHYS_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [WD_W-1:0] r_wait;
  phys_state_t     r_lastState;
  logic            r_timeoutErr;
  logic            w_doneNow;

  // r_wait holds the number of cycles spent in the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait      <= '0;
      r_lastState <= S_IDLE;
    end else begin
      r_lastState <= r_state;
      r_wait      <= (r_state != r_lastState) ? WD_W'(1) : r_wait + WD_W'(1);
    end
  end

  assign w_doneNow = ((r_state == S_COLLIDE) && bus.collide_done) ||
                     ((r_state == S_MOVE)    && bus.move_done)    ||
                     ((r_state == S_SCROLL)  && bus.scroll_done);
  assign w_timeout = ((r_state == S_COLLIDE) || (r_state == S_MOVE) || (r_state == S_SCROLL)) &&
                     (r_state == r_lastState) && !w_doneNow &&
                     (r_wait == WD_W'(TIMEOUT - 1));
  assign bus.timeout_err = r_timeoutErr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_timeoutErr <= 1'b0;
    else if (w_timeout) r_timeoutErr <= 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Each request rises on entry to its state and falls on the edge its done is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_collideReq   <= 1'b0;
      r_moveReq      <= 1'b0;
      r_scrollReq    <= 1'b0;
      r_hit          <= 1'b0;
      r_gameOver     <= 1'b0;
      r_overrun      <= 1'b0;
      r_scrollAmount <= '0;
      r_frameCount   <= '0;
    end else begin
      if (w_tick && isBusy(r_state)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (bus.enable) r_state <= S_WAIT_TICK;
        S_WAIT_TICK: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            r_state      <= S_COLLIDE;
            r_collideReq <= 1'b1;
          end
        end
        S_COLLIDE: begin
          if (bus.collide_done) begin
            r_collideReq <= 1'b0;
            r_hit        <= bus.collide_hit;
            if (bus.falling && !bus.collide_hit && (bus.doodle_y == '0)) begin
              r_state    <= S_OVER;
              r_gameOver <= 1'b1;
            end else begin
              r_state   <= S_MOVE;
              r_moveReq <= 1'b1;
            end
          end
        end
        S_MOVE: begin
          if (bus.move_done) begin
            r_moveReq <= 1'b0;
            r_state   <= S_DECIDE;
          end
        end
        // doodle_y is only trusted one cycle after the move step finished.
        S_DECIDE: begin
          if (bus.doodle_y > SCROLL_Y) begin
            r_scrollAmount <= bus.doodle_y - SCROLL_Y;
            r_scrollReq    <= 1'b1;
            r_state        <= S_SCROLL;
          end else begin
            r_frameCount <= r_frameCount + 16'd1;
            r_state      <= bus.enable ? S_WAIT_TICK : S_IDLE;
          end
        end
        S_SCROLL: begin
          if (bus.scroll_done) begin
            r_scrollReq    <= 1'b0;
            r_scrollAmount <= '0;
            r_frameCount   <= r_frameCount + 16'd1;
            r_state        <= bus.enable ? S_WAIT_TICK : S_IDLE;
          end
        end
        S_OVER:  r_state <= S_OVER;
        default: r_state <= S_IDLE;
      endcase
      if (w_timeout) begin
        r_collideReq   <= 1'b0;
        r_moveReq      <= 1'b0;
        r_scrollReq    <= 1'b0;
        r_scrollAmount <= '0;
        r_state        <= S_WAIT_TICK;
      end
    end
  end

  assign bus.collide_req   = r_collideReq;
  assign bus.move_req      = r_moveReq;
  assign bus.scroll_req    = r_scrollReq;
  assign bus.scroll_amount = r_scrollAmount;
  assign bus.hit           = r_hit;
  assign bus.busy          = isBusy(r_state);
  assign bus.game_over     = r_gameOver;
  assign bus.overrun       = r_overrun;
  assign bus.frame_count   = r_frameCount;

endmodule

// File: tb/tb_physics_sequencer.sv
// Directed bench for physics_sequencer with TICK_DIV=10, SCROLL_LINE=300.
// Automatic done responders answer each request after a programmable delay.
module tb_physics_sequencer;
  import phys_pkg::*;

  localparam int SIG_COLLIDE = 0;
  localparam int SIG_MOVE    = 1;
  localparam int SIG_SCROLL  = 2;
  localparam int SIG_OVER    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;
  int   collideDelay = 1;
  int   moveDelay    = 1;
  int   scrollDelay  = 1;
  int   cWait = 0;
  int   mWait = 0;
  int   sWait = 0;
  int   collideRises = 0;
  int   scrollHighCycles = 0;
  logic prevCollide = 1'b0;
  int   cycles;

  physics_sequencer_if bus();

  physics_sequencer #(
    .TICK_DIV    (10),
    .SCROLL_LINE (300)
`ifdef PHYS_WATCHDOG_EN
    ,
    .TIMEOUT     (20)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Responders raise done after the programmed number of cycles; a delay <= 0 never answers.
  always @(negedge clk) begin
    if (!bus.collide_req) begin
      bus.collide_done = 1'b0;
      cWait = 0;
    end else if (!bus.collide_done) begin
      cWait = cWait + 1;
      if (collideDelay > 0 && cWait >= collideDelay) bus.collide_done = 1'b1;
    end
    if (!bus.move_req) begin
      bus.move_done = 1'b0;
      mWait = 0;
    end else if (!bus.move_done) begin
      mWait = mWait + 1;
      if (moveDelay > 0 && mWait >= moveDelay) bus.move_done = 1'b1;
    end
    if (!bus.scroll_req) begin
      bus.scroll_done = 1'b0;
      sWait = 0;
    end else if (!bus.scroll_done) begin
      sWait = sWait + 1;
      if (scrollDelay > 0 && sWait >= scrollDelay) bus.scroll_done = 1'b1;
    end
    if (bus.collide_req && !prevCollide) collideRises = collideRises + 1;
    prevCollide = bus.collide_req;
    if (bus.scroll_req) scrollHighCycles = scrollHighCycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] y, input logic fall,
                               input logic hitIn);
    bus.enable      = en;
    bus.doodle_y    = y;
    bus.falling     = fall;
    bus.collide_hit = hitIn;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic getSig(input int sel);
    case (sel)
      SIG_COLLIDE: return bus.collide_req;
      SIG_MOVE:    return bus.move_req;
      SIG_SCROLL:  return bus.scroll_req;
      default:     return bus.game_over;
    endcase
  endfunction

  // Counts clock edges until the selected output reaches the wanted level.
  task automatic waitSignal(input string tag, input int sel, input logic level,
                            input int limit, output int n);
    n = 0;
    while (getSig(sel) !== level && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (getSig(sel) !== level) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    collideRises     = 0;
    scrollHighCycles = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    bus.collide_done = 1'b0;
    bus.move_done    = 1'b0;
    bus.scroll_done  = 1'b0;
    waitCycles(2);
    checkOutput("rst_collide_req", 32'(bus.collide_req), 32'd0);
    checkOutput("rst_move_req", 32'(bus.move_req), 32'd0);
    checkOutput("rst_scroll_req", 32'(bus.scroll_req), 32'd0);
    checkOutput("rst_scroll_amount", bus.scroll_amount, 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_game_over", 32'(bus.game_over), 32'd0);
    checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
    checkOutput("rst_frame_count", 32'(bus.frame_count), 32'd0);
    checkOutput("rst_hit", 32'(bus.hit), 32'd0);
    reset = 1'b0;

    $display("[TB] plain frames without scroll");
    applyStimulus(1'b1, 32'd100, 1'b0, 1'b0);
    waitSignal("first_collide", SIG_COLLIDE, 1'b1, 30, cycles);
    checkOutput("first_collide_latency", cycles, 32'd11);
    checkOutput("first_collide_busy", 32'(bus.busy), 32'd1);
    waitCycles(1);
    checkOutput("move_after_collide", 32'(bus.move_req), 32'd1);
    checkOutput("collide_dropped", 32'(bus.collide_req), 32'd0);
    waitCycles(2);
    checkOutput("frame1_count", 32'(bus.frame_count), 32'd1);
    checkOutput("frame1_busy", 32'(bus.busy), 32'd0);
    bus.doodle_y = 32'd300;
    waitCycles(10);
    checkOutput("frame2_line_count", 32'(bus.frame_count), 32'd2);
    bus.enable = 1'b0;
    waitCycles(3);
    checkOutput("noscroll_scroll_cycles", scrollHighCycles, 32'd0);
    checkOutput("noscroll_collide_rises", collideRises, 32'd2);
    checkOutput("noscroll_overrun", 32'(bus.overrun), 32'd0);

    $display("[TB] frame with scroll");
    resetDut();
    scrollDelay = 3;
    applyStimulus(1'b1, 32'd350, 1'b0, 1'b1);
    waitSignal("scroll_req", SIG_SCROLL, 1'b1, 40, cycles);
    checkOutput("scroll_amount", bus.scroll_amount, 32'd50);
    checkOutput("scroll_hit", 32'(bus.hit), 32'd1);
    waitCycles(1);
    checkOutput("scroll_amount_held", bus.scroll_amount, 32'd50);
    checkOutput("scroll_req_held", 32'(bus.scroll_req), 32'd1);
    checkOutput("scroll_frame_before", 32'(bus.frame_count), 32'd0);
    waitSignal("scroll_end", SIG_SCROLL, 1'b0, 10, cycles);
    checkOutput("scroll_amount_cleared", bus.scroll_amount, 32'd0);
    checkOutput("scroll_frame_count", 32'(bus.frame_count), 32'd1);
    bus.enable = 1'b0;
    scrollDelay = 1;

    $display("[TB] overrun from slow collision check");
    resetDut();
    collideDelay = 15;
    applyStimulus(1'b1, 32'd100, 1'b0, 1'b0);
    waitSignal("ovr_collide", SIG_COLLIDE, 1'b1, 30, cycles);
    waitSignal("ovr_collide_end", SIG_COLLIDE, 1'b0, 30, cycles);
    checkOutput("ovr_collide_hold", cycles, 32'd15);
    checkOutput("ovr_overrun", 32'(bus.overrun), 32'd1);
    waitCycles(2);
    checkOutput("ovr_frame_count", 32'(bus.frame_count), 32'd1);
    bus.enable = 1'b0;
    waitCycles(3);
    checkOutput("ovr_collide_rises", collideRises, 32'd1);
    collideDelay = 1;

    $display("[TB] game over");
    resetDut();
    applyStimulus(1'b1, 32'd0, 1'b1, 1'b0);
    waitSignal("over_flag", SIG_OVER, 1'b1, 30, cycles);
    checkOutput("over_latency", cycles, 32'd12);
    collideRises = 0;
    waitCycles(35);
    checkOutput("over_sticky", 32'(bus.game_over), 32'd1);
    checkOutput("over_no_requests", collideRises, 32'd0);
    checkOutput("over_move_req", 32'(bus.move_req), 32'd0);
    checkOutput("over_busy", 32'(bus.busy), 32'd0);
    checkOutput("over_frame_count", 32'(bus.frame_count), 32'd0);
    resetDut();
    checkOutput("over_cleared", 32'(bus.game_over), 32'd0);

    $display("[TB] reset during move handshake");
    moveDelay = 0;
    applyStimulus(1'b1, 32'd100, 1'b0, 1'b1);
    waitSignal("rm_move", SIG_MOVE, 1'b1, 30, cycles);
    checkOutput("rm_hit_before", 32'(bus.hit), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rm_move_req_async", 32'(bus.move_req), 32'd0);
    checkOutput("rm_busy_async", 32'(bus.busy), 32'd0);
    checkOutput("rm_hit_async", 32'(bus.hit), 32'd0);
    moveDelay = 1;
    waitCycles(2);
    reset = 1'b0;
    waitSignal("rm_restart", SIG_COLLIDE, 1'b1, 30, cycles);
    checkOutput("rm_restart_latency", cycles, 32'd11);
    bus.enable = 1'b0;
    waitCycles(5);

`ifdef PHYS_WATCHDOG_EN
    $display("[TB] watchdog on stalled move");
    resetDut();
    moveDelay = 0;
    applyStimulus(1'b1, 32'd100, 1'b0, 1'b0);
    waitSignal("wd_move", SIG_MOVE, 1'b1, 30, cycles);
    waitSignal("wd_move_drop", SIG_MOVE, 1'b0, 40, cycles);
    checkOutput("wd_move_hold", cycles, 32'd20);
    checkOutput("wd_timeout_err", 32'(bus.timeout_err), 32'd1);
    checkOutput("wd_frame_count", 32'(bus.frame_count), 32'd0);
    waitSignal("wd_next_collide", SIG_COLLIDE, 1'b1, 30, cycles);
    checkOutput("wd_next_collide_seen", 32'(bus.collide_req), 32'd1);
    bus.enable = 1'b0;
    moveDelay = 1;
    waitCycles(5);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/physics_sequencer.md
Name: physics_sequencer

Overview:
- Per-frame controller for the doodle physics datapath.
- Divides the system clock into a physics tick.
- On each tick, runs one fixed sequence with req/done handshakes: collision check, then doodle position step, then screen scroll (only when needed).
- Sits between the top-level game FSM and the doodle, collision and block/scroll managers; detects game over.

Parameters:
- TICK_DIV, 833333: clk cycles per physics tick (60 Hz at 50 MHz); minimum 4.
- SCROLL_LINE, 300: doodle Y above which the screen scrolls down.
- TIMEOUT, 255: max cycles to wait for any done (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request from game FSM
- doodle_y  in  32  current doodle Y (unsigned)
- falling  in  1  doodle moving downward
- collide_req  out  1  request collision check
- collide_done  in  1  collision check complete
- collide_hit  in  1  check result, valid when collide_done=1
- hit  out  1  registered collide_hit from last completed check; drives hasCollide
- move_req  out  1  request one doodle position step (physicsUpdate)
- move_done  in  1  position step complete
- scroll_req  out  1  request scroll of all blocks
- scroll_amount  out  32  pixels to scroll, stable while scroll_req=1
- scroll_done  in  1  scroll complete
- busy  out  1  FSM outside IDLE/WAIT_TICK/OVER
- game_over  out  1  sticky loss flag
- overrun  out  1  sticky: a tick arrived while busy
- frame_count  out  16  completed sequences, wraps at 0xFFFF→0

Behaviour:
- Reset (async, active-high): all outputs 0, FSM=IDLE, tick counter=0. Reset mid-handshake drops every req in the same instant.
- Tick counter: counts 0..TICK_DIV-1 while enable=1, else held at 0. tick = one-cycle pulse when counter wraps from TICK_DIV-1 to 0.
- States: IDLE, WAIT_TICK, COLLIDE, MOVE, SCROLL, OVER.
- IDLE→WAIT_TICK when enable=1.
- WAIT_TICK→COLLIDE on tick. WAIT_TICK→IDLE if enable=0.
- Handshake, all three reqs:
  - req rises on the cycle the state is entered and is held until done=1 is sampled.
  - req is low the cycle after done; FSM advances on that same edge.
  - done while its req=0 is ignored. Back-to-back req of different types never overlap.
- COLLIDE:
  - On collide_done, hit<=collide_hit.
  - If falling=1, collide_hit=0 and doodle_y==0: → OVER.
  - Otherwise → MOVE.
- MOVE: on move_done, sample doodle_y one cycle later, in the decision state.
  - If doodle_y>SCROLL_LINE: scroll_amount<=doodle_y-SCROLL_LINE (32-bit unsigned; never negative by construction), → SCROLL.
  - Else frame_count++, → WAIT_TICK (or IDLE if enable=0).
- SCROLL: on scroll_done, scroll_amount<=0, frame_count++, → WAIT_TICK/IDLE per enable.
- enable=0 mid-sequence: the current sequence completes, then → IDLE. No sequence is aborted.
- Tick while busy=1: tick dropped (not queued), overrun<=1 sticky until reset.
- Tick on the same cycle the sequence returns to WAIT_TICK: that tick is missed, overrun=1.
- OVER: game_over=1, all reqs 0, counter frozen. Exit only by reset.
- Minimum sequence latency: tick→COLLIDE 1 cycle; each handshake ≥2 cycles.

Optional Feature:
- Macro: PHYS_WATCHDOG_EN.
- Defined:
  - An 8+-bit wait counter resets on each state entry.
  - If req is held TIMEOUT cycles without done: drop req, set sticky port timeout_err (extra 1-bit output), → WAIT_TICK without incrementing frame_count.
- Undefined: no counter, no timeout_err port; FSM waits indefinitely.

Decomposition:
- Shared package phys_pkg:
  - state enum (IDLE..OVER, 3 bits)
  - DEFAULT_TICK_DIV, DEFAULT_SCROLL_LINE
  - coordinate width constant COORD_W=32, shared with doodle and block managers
- One sub-module: tick_divider (parameter TICK_DIV; enable in, tick out). Reused by the block-spawn logic.

Test Plan:
- TICK_DIV=10, enable=1, all done responders 1-cycle: collide_req first rises at cycle 11 after enable. One full frame without scroll (doodle_y=100) → frame_count=1, scroll_req never high.
- doodle_y=350 after move_done, SCROLL_LINE=300 → scroll_req=1 with scroll_amount=50 until scroll_done, then scroll_amount=0, frame_count=1.
- falling=1, doodle_y=0, collide_hit=0 → game_over=1 and stays 1. Further ticks produce no req. After reset, game_over=0.
- collide_done delayed 15 cycles with TICK_DIV=10 → overrun=1; no second collide_req during the sequence; frame_count=1 after completion.
- Reset asserted while move_req=1 → move_req=0 immediately (before next clk edge); all outputs 0; FSM restarts from IDLE.
- PHYS_WATCHDOG_EN, TIMEOUT=20, move_done never asserted → move_req drops after 20 cycles; timeout_err=1; next tick yields a new collide_req.
